// File: rtl/typing_pkg.sv
// Shared encodings for the keypad typing-test core: display modes, key codes, FSM states.
package typing_pkg;

  localparam logic [1:0] MODE_SELECT = 2'd0;
  localparam logic [1:0] MODE_TEST   = 2'd1;
  localparam logic [1:0] MODE_RESULT = 2'd2;

  localparam logic [3:0] KEY_START = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;

  localparam int unsigned SECS_PER_MIN = 60;

  typedef enum logic [2:0] {
    ST_SELECT,
    ST_CONV,
    ST_TEST,
    ST_DIV,
    ST_RESULT
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring shift-subtract unsigned divider producing one quotient bit per clock.
module seq_divider #(
  parameter int unsigned DIVIDEND_W = 22,
  parameter int unsigned DIVISOR_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int unsigned CNT_BITS = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DIVISOR_W:0]    shifted;

  // The partial remainder stays below the divisor, so it fits DIVISOR_W bits.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[DIVIDEND_W-1]};
    if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
      cnt_d  = CNT_BITS'(DIVIDEND_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (shifted >= {1'b0, dvs_q}) begin
        rem_d = DIVISOR_W'(shifted - {1'b0, dvs_q});
        quo_d = {quo_q[DIVIDEND_W-2:0], 1'b1};
      end else begin
        rem_d = shifted[DIVISOR_W-1:0];
        quo_d = {quo_q[DIVIDEND_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_BITS'(1);
      if (cnt_q == CNT_BITS'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/typing_test_core.sv
// Keypad typing-test game core: target entry, word typing with miss/time counting,
// and a words-per-minute result from a sequential divider.
module typing_test_core
  import typing_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WPM_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sec_tick,
  input  logic                  key_level,
  input  logic [3:0]            key_code,
  input  logic [4*N_DIGITS-1:0] rand_word,
  output logic [4*N_DIGITS-1:0] disp_digits,
  output logic [N_DIGITS-1:0]   disp_en,
  output logic [1:0]            mode,
  output logic [CNT_W-1:0]      missed,
  output logic [CNT_W-1:0]      elapsed,
  output logic [CNT_W-1:0]      completed,
  output logic [WPM_W-1:0]      wpm,
  output logic                  result_valid
);

  localparam int unsigned DISP_W = 4 * N_DIGITS;
  localparam int unsigned CUR_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned DVD_W  = CNT_W + 6;
  localparam int unsigned ACC_W  = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CUR_W-1:0] CUR_TOP = CUR_W'(N_DIGITS - 1);

  state_t             state_q, state_d;
  logic               key_last_q, key_last_d;
  logic               press_q, press_d;
  logic [DISP_W-1:0]  target_bcd_q, target_bcd_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [CUR_W-1:0]   conv_idx_q, conv_idx_d;
  logic [DISP_W-1:0]  word_q, word_d;
  logic [CUR_W-1:0]   cursor_q, cursor_d;
  logic [CNT_W-1:0]   missed_q, missed_d;
  logic [CNT_W-1:0]   elapsed_q, elapsed_d;
  logic [CNT_W-1:0]   completed_q, completed_d;
  logic [WPM_W-1:0]   wpm_q, wpm_d;
  logic               result_valid_q, result_valid_d;
  logic [N_DIGITS-1:0] disp_en_q, disp_en_d;
  logic [DISP_W-1:0]  disp_q, disp_d;
  logic [1:0]         mode_q, mode_d;
  logic               div_start_q, div_start_d;

  logic               key_is_digit, key_is_start, key_is_back;
  logic [3:0]         cur_digit, conv_digit;
  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   target_sat;
  logic [CNT_W-1:0]   missed_inc, elapsed_inc, completed_inc;
  logic [DVD_W-1:0]   div_dividend, div_quotient;
  logic [CNT_W-1:0]   div_divisor;
  logic               div_busy, div_done, div_fire;
  logic [WPM_W-1:0]   wpm_sat;

  assign key_is_digit = press_q && (key_code <= 4'd9);
  assign key_is_start = press_q && (key_code == KEY_START);
  assign key_is_back  = press_q && (key_code == KEY_BACK);

  assign cur_digit  = word_q[{cursor_q, 2'b00} +: 4];
  assign conv_digit = target_bcd_q[{conv_idx_q, 2'b00} +: 4];

  // Decimal accumulation of the entered target, most significant digit first.
  assign acc_next   = ACC_W'(target_q) * ACC_W'(10) + ACC_W'(conv_digit);
  assign target_sat = (acc_next > ACC_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(acc_next);

  assign missed_inc    = (missed_q == CNT_MAX)    ? missed_q    : missed_q + CNT_W'(1);
  assign elapsed_inc   = (elapsed_q == CNT_MAX)   ? elapsed_q   : elapsed_q + CNT_W'(1);
  assign completed_inc = (completed_q == CNT_MAX) ? completed_q : completed_q + CNT_W'(1);

  assign div_dividend = DVD_W'(completed_q) * DVD_W'(SECS_PER_MIN);
  assign div_divisor  = (elapsed_q == '0) ? CNT_W'(1) : elapsed_q;
  // A done left over from an aborted run must not end a freshly started division.
  assign div_fire     = div_done && !div_busy && !div_start_q;
  assign wpm_sat      = ((div_quotient >> WPM_W) != '0) ? {WPM_W{1'b1}} : WPM_W'(div_quotient);

  seq_divider #(
    .DIVIDEND_W (DVD_W),
    .DIVISOR_W  (CNT_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_q),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_comb begin
    state_d        = state_q;
    key_last_d     = key_level;
    press_d        = key_level & ~key_last_q;
    target_bcd_d   = target_bcd_q;
    target_d       = target_q;
    conv_idx_d     = conv_idx_q;
    word_d         = word_q;
    cursor_d       = cursor_q;
    missed_d       = missed_q;
    elapsed_d      = elapsed_q;
    completed_d    = completed_q;
    wpm_d          = wpm_q;
    result_valid_d = result_valid_q;
    disp_en_d      = disp_en_q;
    div_start_d    = 1'b0;

    case (state_q)
      ST_SELECT: begin
        if (key_is_digit) begin
          target_bcd_d = DISP_W'({target_bcd_q, key_code});
        end else if (key_is_back) begin
          target_bcd_d = '0;
        end else if (key_is_start && (target_bcd_q != '0)) begin
          state_d    = ST_CONV;
          target_d   = '0;
          conv_idx_d = CUR_TOP;
        end
      end

      ST_CONV: begin
        target_d   = target_sat;
        conv_idx_d = conv_idx_q - CUR_W'(1);
        if (conv_idx_q == '0) begin
          word_d      = rand_word;
          missed_d    = '0;
          elapsed_d   = '0;
          completed_d = '0;
          cursor_d    = CUR_TOP;
          state_d     = ST_TEST;
        end
      end

      ST_TEST: begin
        if (sec_tick) begin
          elapsed_d = elapsed_inc;
        end
        if (key_is_back) begin
          state_d     = ST_SELECT;
          missed_d    = '0;
          elapsed_d   = '0;
          completed_d = '0;
        end else if (key_is_digit) begin
          if (key_code != cur_digit) begin
            missed_d = missed_inc;
          end else if (cursor_q != '0) begin
            disp_en_d[cursor_q] = 1'b0;
            cursor_d            = cursor_q - CUR_W'(1);
          end else begin
            completed_d = completed_inc;
            if (completed_inc == target_q) begin
              state_d     = ST_DIV;
              div_start_d = 1'b1;
            end else begin
              word_d    = rand_word;
              disp_en_d = '1;
              cursor_d  = CUR_TOP;
            end
          end
        end
      end

      ST_DIV: begin
        if (key_is_back) begin
          state_d     = ST_SELECT;
          missed_d    = '0;
          elapsed_d   = '0;
          completed_d = '0;
        end else if (div_fire) begin
          wpm_d          = wpm_sat;
          result_valid_d = 1'b1;
          state_d        = ST_RESULT;
        end
      end

      ST_RESULT: begin
        if (key_is_back) begin
          state_d        = ST_SELECT;
          missed_d       = '0;
          elapsed_d      = '0;
          completed_d    = '0;
          wpm_d          = '0;
          result_valid_d = 1'b0;
        end
      end

      default: state_d = ST_SELECT;
    endcase

    // Digit masking only applies while a word is being typed.
    if (state_d != ST_TEST) begin
      disp_en_d = '1;
    end

    case (state_d)
      ST_SELECT: begin
        mode_d = MODE_SELECT;
        disp_d = target_bcd_d;
      end
      ST_CONV: begin
        mode_d = MODE_TEST;
        disp_d = target_bcd_d;
      end
      ST_RESULT: begin
        mode_d = MODE_RESULT;
        disp_d = DISP_W'(wpm_d);
      end
      default: begin
        mode_d = MODE_TEST;
        disp_d = word_d;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_SELECT;
      key_last_q     <= 1'b0;
      press_q        <= 1'b0;
      target_bcd_q   <= '0;
      target_q       <= '0;
      conv_idx_q     <= '0;
      word_q         <= '0;
      cursor_q       <= '0;
      missed_q       <= '0;
      elapsed_q      <= '0;
      completed_q    <= '0;
      wpm_q          <= '0;
      result_valid_q <= 1'b0;
      disp_en_q      <= '1;
      disp_q         <= '0;
      mode_q         <= MODE_SELECT;
      div_start_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_last_q     <= key_last_d;
      press_q        <= press_d;
      target_bcd_q   <= target_bcd_d;
      target_q       <= target_d;
      conv_idx_q     <= conv_idx_d;
      word_q         <= word_d;
      cursor_q       <= cursor_d;
      missed_q       <= missed_d;
      elapsed_q      <= elapsed_d;
      completed_q    <= completed_d;
      wpm_q          <= wpm_d;
      result_valid_q <= result_valid_d;
      disp_en_q      <= disp_en_d;
      disp_q         <= disp_d;
      mode_q         <= mode_d;
      div_start_q    <= div_start_d;
    end
  end

  assign disp_digits  = disp_q;
  assign disp_en      = disp_en_q;
  assign mode         = mode_q;
  assign missed       = missed_q;
  assign elapsed      = elapsed_q;
  assign completed    = completed_q;
  assign wpm          = wpm_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_typing_test_core.sv
// Directed-plus-random bench for typing_test_core against a word/cursor level game model.
module tb_typing_test_core;
  import typing_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned WW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sec_tick = 1'b0;
  logic            key_level = 1'b0;
  logic [3:0]      key_code = 4'h0;
  logic [4*N-1:0]  rand_word = '0;
  logic [4*N-1:0]  disp_digits;
  logic [N-1:0]    disp_en;
  logic [1:0]      mode;
  logic [CW-1:0]   missed;
  logic [CW-1:0]   elapsed;
  logic [CW-1:0]   completed;
  logic [WW-1:0]   wpm;
  logic            result_valid;

  int vectors = 0;
  int miscompares = 0;

  int             m_target, m_missed, m_elapsed, m_completed, m_cursor;
  bit             m_in_div;
  logic [4*N-1:0] m_word, m_bcd;

  typing_test_core #(.N_DIGITS(N), .CNT_W(CW), .WPM_W(WW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sec_tick     (sec_tick),
    .key_level    (key_level),
    .key_code     (key_code),
    .rand_word    (rand_word),
    .disp_digits  (disp_digits),
    .disp_en      (disp_en),
    .mode         (mode),
    .missed       (missed),
    .elapsed      (elapsed),
    .completed    (completed),
    .wpm          (wpm),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*N-1:0] rand_bcd();
    logic [4*N-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
    return w;
  endfunction

  function automatic logic [3:0] wrong_of(input logic [3:0] good);
    return 4'((32'(good) + 1 + $urandom_range(0, 8)) % 10);
  endfunction

  task automatic press(input logic [3:0] k, input bit tick);
    @(negedge clk);
    key_code  = k;
    key_level = 1'b1;
    @(negedge clk);
    if (tick) sec_tick = 1'b1;
    @(negedge clk);
    sec_tick  = 1'b0;
    key_level = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic tick_once();
    @(negedge clk);
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
    m_elapsed++;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_missed"}, 32'(missed), 32'(m_missed));
    chk({tag, "_elapsed"}, 32'(elapsed), 32'(m_elapsed));
    chk({tag, "_completed"}, 32'(completed), 32'(m_completed));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mode"}, 32'(mode), 32'(MODE_SELECT));
    chk({tag, "_disp"}, 32'(disp_digits), 32'h0);
    chk({tag, "_disp_en"}, 32'(disp_en), 32'hF);
    chk({tag, "_missed"}, 32'(missed), 32'h0);
    chk({tag, "_elapsed"}, 32'(elapsed), 32'h0);
    chk({tag, "_completed"}, 32'(completed), 32'h0);
    chk({tag, "_wpm"}, 32'(wpm), 32'h0);
    chk({tag, "_valid"}, 32'(result_valid), 32'h0);
  endtask

  // Enter the target as N decimal digits, then start the test.
  task automatic enter_target(input int t);
    int tmp;
    m_target = t;
    tmp = t;
    m_bcd = '0;
    for (int i = 0; i < N; i++) begin
      m_bcd[4*i +: 4] = 4'(tmp % 10);
      tmp = tmp / 10;
    end
    for (int i = N - 1; i >= 0; i--) press(m_bcd[4*i +: 4], 1'b0);
    chk("select_disp", 32'(disp_digits), 32'(m_bcd));
    press(KEY_START, 1'b0);
    repeat (N + 2) @(negedge clk);
    m_word = rand_word;
    rand_word = rand_bcd();
    m_cursor = N - 1;
    m_missed = 0;
    m_elapsed = 0;
    m_completed = 0;
    m_in_div = 1'b0;
    chk("start_mode", 32'(mode), 32'(MODE_TEST));
    chk("start_disp", 32'(disp_digits), 32'(m_word));
    chk("start_disp_en", 32'(disp_en), 32'hF);
  endtask

  task automatic type_key(input logic [3:0] d, input bit tick);
    press(d, tick);
    if (tick) m_elapsed++;
    if (d <= 4'd9) begin
      if (d == m_word[4*m_cursor +: 4]) begin
        if (m_cursor > 0) begin
          m_cursor--;
        end else begin
          m_completed++;
          if (m_completed == m_target) begin
            m_in_div = 1'b1;
          end else begin
            m_word = rand_word;
            rand_word = rand_bcd();
            m_cursor = N - 1;
          end
        end
      end else begin
        m_missed++;
      end
    end
    check_counters("key");
    if (!m_in_div) begin
      chk("key_disp_en", 32'(disp_en), 32'((1 << (m_cursor + 1)) - 1));
      chk("key_disp", 32'(disp_digits), 32'(m_word));
    end
  endtask

  task automatic type_rest(input bit rand_ticks, input bit tick_on_last);
    logic [3:0] good, ign;
    bit         last;
    int         guard;
    guard = 0;
    while (!m_in_div && guard < 100) begin
      guard++;
      good = m_word[4*m_cursor +: 4];
      last = (m_cursor == 0) && (m_completed + 1 == m_target);
      if ($urandom_range(0, 5) == 0) begin
        ign = 4'($urandom_range(12, 16) % 16);
        if (ign == 4'h0) ign = KEY_START;
        type_key(ign, 1'b0);
      end
      if ($urandom_range(0, 3) == 0) type_key(wrong_of(good), 1'b0);
      if (rand_ticks && $urandom_range(0, 3) == 0) begin
        tick_once();
        chk("tick_elapsed", 32'(elapsed), 32'(m_elapsed));
      end
      type_key(good, last && tick_on_last);
    end
    chk("reached_div", 32'(m_in_div), 32'h1);
  endtask

  task automatic check_result();
    int e, w, cyc;
    cyc = 0;
    while (result_valid !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("result_valid", 32'(result_valid), 32'h1);
    e = (m_elapsed == 0) ? 1 : m_elapsed;
    w = (m_completed * int'(SECS_PER_MIN)) / e;
    if (w > 65535) w = 65535;
    chk("wpm", 32'(wpm), 32'(w));
    chk("result_mode", 32'(mode), 32'(MODE_RESULT));
    chk("result_disp", 32'(disp_digits), 32'(w & 16'hFFFF));
    chk("result_disp_en", 32'(disp_en), 32'hF);
    check_counters("result");
    press(KEY_BACK, 1'b0);
    m_missed = 0;
    m_elapsed = 0;
    m_completed = 0;
    m_in_div = 1'b0;
    chk("back_mode", 32'(mode), 32'(MODE_SELECT));
    chk("back_wpm", 32'(wpm), 32'h0);
    chk("back_valid", 32'(result_valid), 32'h0);
    chk("back_disp", 32'(disp_digits), 32'(m_bcd));
    check_counters("back");
  endtask

  initial begin
    int nt;
    m_target = 0; m_missed = 0; m_elapsed = 0; m_completed = 0; m_cursor = N - 1;
    m_in_div = 1'b0; m_word = '0; m_bcd = '0;
    rand_word = rand_bcd();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // A with an all-zero target must not start a test.
    for (int i = 0; i < N; i++) press(4'h0, 1'b0);
    press(KEY_START, 1'b0);
    repeat (N + 2) @(negedge clk);
    chk("zero_start_mode", 32'(mode), 32'(MODE_SELECT));
    chk("zero_start_disp", 32'(disp_digits), 32'h0);

    press(4'h7, 1'b0);
    chk("entry_disp", 32'(disp_digits), 32'h0007);
    press(KEY_BACK, 1'b0);
    chk("clear_disp", 32'(disp_digits), 32'h0);

    // Target 2, one miss then a hit, 30 seconds, two words.
    enter_target(2);
    type_key(wrong_of(m_word[4*m_cursor +: 4]), 1'b0);
    chk("miss_count", 32'(missed), 32'h1);
    type_key(m_word[4*m_cursor +: 4], 1'b0);
    chk("hit_disp_en", 32'(disp_en), 32'h7);
    for (int i = 0; i < 30; i++) tick_once();
    chk("ticks30", 32'(elapsed), 32'd30);
    type_rest(1'b0, 1'b0);
    check_result();

    // Single word with no time elapsed: divisor clamps to one.
    enter_target(1);
    type_rest(1'b0, 1'b0);
    check_result();

    // Back out of a word part-way through.
    enter_target(3);
    type_key(m_word[4*m_cursor +: 4], 1'b0);
    type_key(m_word[4*m_cursor +: 4], 1'b0);
    type_key(wrong_of(m_word[4*m_cursor +: 4]), 1'b0);
    tick_once();
    chk("mid_cursor_en", 32'(disp_en), 32'h3);
    press(KEY_BACK, 1'b0);
    m_missed = 0; m_elapsed = 0; m_completed = 0;
    chk("mid_back_mode", 32'(mode), 32'(MODE_SELECT));
    chk("mid_back_disp", 32'(disp_digits), 32'(m_bcd));
    chk("mid_back_disp_en", 32'(disp_en), 32'hF);
    check_counters("mid_back");

    // Reset while the divider is running.
    enter_target(1);
    for (int i = 0; i < 5; i++) tick_once();
    type_rest(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("div_mode", 32'(mode), 32'(MODE_TEST));
    chk("div_valid", 32'(result_valid), 32'h0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomised runs, some with a tick landing on the final keystroke.
    for (int r = 0; r < 4; r++) begin
      enter_target($urandom_range(1, 3));
      nt = $urandom_range(0, 40);
      for (int i = 0; i < nt; i++) tick_once();
      type_rest(1'b1, 1'($urandom_range(0, 1)));
      check_result();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
